// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction-memory responder.
//   - FSM state encoding (SERVE, LOAD)
//   - NOP_INSTR, the instruction returned on a faulting fetch
//   - addr_fault(): alignment and range check for fetch addresses
package imem_pkg;

  typedef logic [0:0] imem_state_t;

  localparam imem_state_t ST_SERVE = 1'b0;
  localparam imem_state_t ST_LOAD  = 1'b1;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // A fetch faults when it is not word aligned or when it lies at or beyond
  // the end of the RAM. limit_bytes is one bit wider than the address so the
  // largest legal depth does not wrap.
  function automatic logic addr_fault(input logic [31:0] addr,
                                      input logic [32:0] limit_bytes);
    return (addr[1:0] != 2'b00) || ({1'b0, addr} >= limit_bytes);
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// imem_byte_packer: assembles a little-endian 32-bit word from a byte stream.
//   clk, rst     clock and asynchronous active-high reset
//   clear        drop any partial word and restart at lane 0
//   in_valid     in_byte is accepted this cycle
//   in_byte      data byte, placed in the current lane
//   in_last      final byte of the stream; flushes a partial word
//   word_valid   word is complete this cycle (lane 3 or in_last)
//   word         assembled word, unfilled upper lanes read as 0x00
module imem_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane_reg;
  logic [31:0] acc_reg;
  logic [31:0] byte_placed;

  // Steer the incoming byte into its lane; every other lane contributes zero.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign byte_placed[gi*8 +: 8] = (lane_reg == 2'(gi)) ? in_byte : 8'h00;
  end

  // acc_reg keeps unfilled lanes at zero, so OR-ing in the new byte yields
  // the zero-padded word directly.
  assign word       = acc_reg | byte_placed;
  assign word_valid = in_valid && !clear && ((lane_reg == 2'd3) || in_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_reg <= '0;
      acc_reg  <= '0;
    end else if (clear) begin
      lane_reg <= '0;
      acc_reg  <= '0;
    end else if (in_valid) begin
      if (word_valid) begin
        lane_reg <= '0;
        acc_reg  <= '0;
      end else begin
        lane_reg <= lane_reg + 2'd1;
        acc_reg  <= word;
      end
    end
  end

endmodule

// File: rtl/imem_responder.sv
// imem_responder: word-organised instruction RAM serving IF-stage fetches with
// one-cycle latency, plus an optional byte-serial program loader.
//
// Build option: define IMEM_LOADER_EN to include the loader and LOAD state.
// Without it the ld_* inputs are ignored, ld_* outputs read 0 and the RAM is
// filled only from INIT_FILE.
//
// Parameters:
//   DEPTH_WORDS  RAM depth in 32-bit words (power of two, >= 4)
//   INIT_FILE    hex image name, empty for none
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   req_valid/req_ready/req_addr   fetch request (byte address)
//   flush                      kill the response being registered this cycle
//   rsp_valid/rsp_rdata/rsp_fault  registered one-cycle response
//   ld_start                   (re)enter LOAD at word 0
//   ld_valid/ld_ready/ld_byte/ld_last  loader byte stream
//   ld_count                   words written since the last ld_start
//   ld_overflow                sticky: bytes arrived while the RAM was full
module imem_responder import imem_pkg::*; #(
  parameter int DEPTH_WORDS = 1024,
  parameter     INIT_FILE   = ""
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [31:0]                  req_addr,
  input  logic                         flush,
  output logic                         rsp_valid,
  output logic [31:0]                  rsp_rdata,
  output logic                         rsp_fault,
  input  logic                         ld_start,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [7:0]                   ld_byte,
  input  logic                         ld_last,
  output logic [$clog2(DEPTH_WORDS):0] ld_count,
  output logic                         ld_overflow
);

  localparam int          AW          = $clog2(DEPTH_WORDS);
  localparam int          CW          = AW + 1;
  localparam logic [32:0] LIMIT_BYTES = 33'(DEPTH_WORDS) << 2;

  logic [31:0] mem [DEPTH_WORDS];

  // ---------------------------------------------------------------------
  // Fetch path
  // ---------------------------------------------------------------------
  logic          accept;
  logic          take;
  logic          fault;
  logic [AW-1:0] rd_idx;
  logic          rsp_valid_reg;
  logic [31:0]   rsp_rdata_reg;
  logic          rsp_fault_reg;

  assign accept = req_valid && req_ready;
  // A flushed request is dropped entirely; rsp_rdata keeps its old value.
  assign take   = accept && !flush;
  assign fault  = addr_fault(req_addr, LIMIT_BYTES);
  assign rd_idx = req_addr[AW+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_fault_reg <= 1'b0;
    end else begin
      rsp_valid_reg <= take;
      if (take) begin
        rsp_fault_reg <= fault;
        rsp_rdata_reg <= fault ? NOP_INSTR : mem[rd_idx];
      end
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_fault = rsp_fault_reg;

`ifdef IMEM_LOADER_EN
  // ---------------------------------------------------------------------
  // Loader and FSM
  // ---------------------------------------------------------------------
  imem_state_t   state_reg;
  imem_state_t   state_next;
  logic [CW-1:0] ld_count_reg;
  logic          ld_overflow_reg;
  logic          byte_acc;
  logic          ram_full;
  logic          pk_word_valid;
  logic [31:0]   pk_word;

  // ld_start dominates both handshakes: it blocks a fetch and supersedes any
  // byte offered in the same cycle.
  assign req_ready = (state_reg == ST_SERVE) && !ld_start;
  assign ld_ready  = (state_reg == ST_LOAD);
  assign byte_acc  = ld_valid && ld_ready && !ld_start;
  assign ram_full  = (ld_count_reg == CW'(DEPTH_WORDS));

  imem_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (ld_start),
    .in_valid   (byte_acc),
    .in_byte    (ld_byte),
    .in_last    (ld_last),
    .word_valid (pk_word_valid),
    .word       (pk_word)
  );

  always_comb begin
    state_next = state_reg;
    if (ld_start) begin
      state_next = ST_LOAD;
    end else if (byte_acc && ld_last) begin
      state_next = ST_SERVE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_SERVE;
      ld_count_reg    <= '0;
      ld_overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (ld_start) begin
        ld_count_reg    <= '0;
        ld_overflow_reg <= 1'b0;
      end else begin
        if (pk_word_valid && !ram_full) begin
          ld_count_reg <= ld_count_reg + CW'(1);
        end
        if (byte_acc && ram_full) begin
          ld_overflow_reg <= 1'b1;
        end
      end
    end
  end

  // RAM write port: no reset, so contents survive rst.
  always_ff @(posedge clk) begin
    if (pk_word_valid && !ram_full) begin
      mem[ld_count_reg[AW-1:0]] <= pk_word;
    end
  end

  assign ld_count    = ld_count_reg;
  assign ld_overflow = ld_overflow_reg;
`else
  // Loader absent: permanently in SERVE.
  logic unused_ld;
  assign unused_ld   = ^{ld_start, ld_valid, ld_byte, ld_last};
  assign req_ready   = 1'b1;
  assign ld_ready    = 1'b0;
  assign ld_count    = '0;
  assign ld_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT with default depth
  logic        req_valid, req_ready, flush;
  logic [31:0] req_addr;
  logic        rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;
  logic        ld_start, ld_valid, ld_ready, ld_last, ld_overflow;
  logic [7:0]  ld_byte;
  logic [10:0] ld_count;

  // DUT with DEPTH_WORDS = 4
  logic        d4_req_valid, d4_req_ready, d4_flush;
  logic [31:0] d4_req_addr;
  logic        d4_rsp_valid, d4_rsp_fault;
  logic [31:0] d4_rsp_rdata;
  logic        d4_ld_start, d4_ld_valid, d4_ld_ready, d4_ld_last, d4_ld_overflow;
  logic [7:0]  d4_ld_byte;
  logic [2:0]  d4_ld_count;

  imem_responder #(.DEPTH_WORDS(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .flush(flush),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_byte(ld_byte), .ld_last(ld_last),
    .ld_count(ld_count), .ld_overflow(ld_overflow)
  );

  imem_responder #(.DEPTH_WORDS(4)) dut4 (
    .clk(clk), .rst(rst),
    .req_valid(d4_req_valid), .req_ready(d4_req_ready), .req_addr(d4_req_addr),
    .flush(d4_flush),
    .rsp_valid(d4_rsp_valid), .rsp_rdata(d4_rsp_rdata), .rsp_fault(d4_rsp_fault),
    .ld_start(d4_ld_start), .ld_valid(d4_ld_valid), .ld_ready(d4_ld_ready),
    .ld_byte(d4_ld_byte), .ld_last(d4_ld_last),
    .ld_count(d4_ld_count), .ld_overflow(d4_ld_overflow)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        rv;
    logic [31:0] addr;
    logic        fl;
    logic        ev;
    logic [31:0] ed;
    logic        ef;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_main(input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    tick();
    req_valid = 1'b0;
    $display("[TB] fetch addr=%h rsp_valid=%0b rdata=%h fault=%0b", a, rsp_valid, rsp_rdata, rsp_fault);
  endtask

  task automatic fetch_d4(input logic [31:0] a);
    d4_req_valid = 1'b1;
    d4_req_addr  = a;
    tick();
    d4_req_valid = 1'b0;
    $display("[TB] d4 fetch addr=%h rsp_valid=%0b rdata=%h fault=%0b", a, d4_rsp_valid, d4_rsp_rdata, d4_rsp_fault);
  endtask

  initial begin
    req_valid = 0; req_addr = 0; flush = 0;
    ld_start = 0; ld_valid = 0; ld_byte = 0; ld_last = 0;
    d4_req_valid = 0; d4_req_addr = 0; d4_flush = 0;
    d4_ld_start = 0; d4_ld_valid = 0; d4_ld_byte = 0; d4_ld_last = 0;

    // Preload the RAM images (stimulus only, written through the hierarchy).
    for (int i = 0; i < 16; i++) begin
      dut.mem[i] <= (i == 3) ? 32'h00500093 : (32'hA0000000 + 32'(i));
    end
    for (int i = 0; i < 4; i++) begin
      dut4.mem[i] <= 32'hA0000000 + 32'(i);
    end

    vecs[0]  = '{1'b1, 32'h0000000C, 1'b0, 1'b1, 32'h00500093, 1'b0};
    vecs[1]  = '{1'b1, 32'h00000000, 1'b0, 1'b1, 32'hA0000000, 1'b0};
    vecs[2]  = '{1'b1, 32'h00000004, 1'b0, 1'b1, 32'hA0000001, 1'b0};
    vecs[3]  = '{1'b1, 32'h00000008, 1'b0, 1'b1, 32'hA0000002, 1'b0};
    vecs[4]  = '{1'b1, 32'h00000006, 1'b0, 1'b1, NOP,          1'b1};
    vecs[5]  = '{1'b1, 32'h00001000, 1'b0, 1'b1, NOP,          1'b1};
    vecs[6]  = '{1'b0, 32'h00000000, 1'b0, 1'b0, NOP,          1'b0};
    vecs[7]  = '{1'b1, 32'h00000010, 1'b1, 1'b0, NOP,          1'b0};
    vecs[8]  = '{1'b1, 32'h00000020, 1'b0, 1'b1, 32'hA0000008, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000003C, 1'b0, 1'b1, 32'hA000000F, 1'b0};
    vecs[10] = '{1'b1, 32'hFFFFFFFC, 1'b0, 1'b1, NOP,          1'b1};
    vecs[11] = '{1'b1, 32'h00000014, 1'b1, 1'b0, NOP,          1'b0};
    vecs[12] = '{1'b1, 32'h00000018, 1'b0, 1'b1, 32'hA0000006, 1'b0};
    vecs[13] = '{1'b1, 32'h00000FFE, 1'b0, 1'b1, NOP,          1'b1};
    vecs[14] = '{1'b1, 32'h00000FFC, 1'b1, 1'b0, NOP,          1'b0};

    // ---------------- reset state ----------------
    tick();
    tick();
    chk("rst rsp_valid",   32'(rsp_valid),   32'd0);
    chk("rst rsp_rdata",   rsp_rdata,        32'd0);
    chk("rst rsp_fault",   32'(rsp_fault),   32'd0);
    chk("rst ld_ready",    32'(ld_ready),    32'd0);
    chk("rst ld_count",    32'(ld_count),    32'd0);
    chk("rst ld_overflow", 32'(ld_overflow), 32'd0);
    chk("rst d4 ld_count", 32'(d4_ld_count), 32'd0);
    rst = 1'b0;
    tick();
    chk("req_ready after rst", 32'(req_ready), 32'd1);

    // ---------------- table-driven fetch vectors ----------------
    for (int i = 0; i < 15; i++) begin
      req_valid = vecs[i].rv;
      req_addr  = vecs[i].addr;
      flush     = vecs[i].fl;
      #1;
      chk($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'd1);
      tick();
      $display("[TB] vec %0d addr=%h flush=%0b rsp_valid=%0b rdata=%h fault=%0b",
               i, vecs[i].addr, vecs[i].fl, rsp_valid, rsp_rdata, rsp_fault);
      chk($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d rsp_rdata", i), rsp_rdata, vecs[i].ed);
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d rsp_fault", i), 32'(rsp_fault), 32'(vecs[i].ef));
      end
    end
    req_valid = 1'b0;
    flush     = 1'b0;
    tick();

`ifdef IMEM_LOADER_EN
    // ---- pending response survives ld_start; ld_start blocks a new fetch ----
    req_valid = 1'b1; req_addr = 32'h8;
    tick();
    ld_start = 1'b1; req_addr = 32'h0;
    #1;
    chk("ldstart req_ready", 32'(req_ready), 32'd0);
    chk("pending rsp_valid", 32'(rsp_valid), 32'd1);
    chk("pending rsp_rdata", rsp_rdata, 32'hA0000002);
    tick();
    ld_start = 1'b0; req_valid = 1'b0;
    chk("ldstart no accept", 32'(rsp_valid), 32'd0);
    chk("load ld_ready",     32'(ld_ready),  32'd1);
    chk("load ld_count0",    32'(ld_count),  32'd0);

    // ---- 5-byte load ----
    begin
      logic [7:0] bytes5 [5];
      bytes5[0] = 8'h93; bytes5[1] = 8'h00; bytes5[2] = 8'h50;
      bytes5[3] = 8'h00; bytes5[4] = 8'h13;
      for (int k = 0; k < 5; k++) begin
        ld_valid = 1'b1; ld_byte = bytes5[k]; ld_last = (k == 4);
        req_valid = 1'b1; req_addr = 32'h0;
        #1;
        chk($sformatf("load byte%0d req_ready", k), 32'(req_ready), 32'd0);
        tick();
        $display("[TB] load byte %0d = %h ld_count=%0d", k, bytes5[k], ld_count);
      end
    end
    ld_valid = 1'b0; ld_last = 1'b0; req_valid = 1'b0;
    chk("load rsp_valid quiet", 32'(rsp_valid), 32'd0);
    chk("load5 ld_count",    32'(ld_count),    32'd2);
    chk("load5 ld_ready",    32'(ld_ready),    32'd0);
    chk("load5 ld_overflow", 32'(ld_overflow), 32'd0);
    chk("load5 req_ready",   32'(req_ready),   32'd1);
    fetch_main(32'h0);
    chk("load5 w0 valid", 32'(rsp_valid), 32'd1);
    chk("load5 w0 data",  rsp_rdata, 32'h00500093);
    chk("load5 w0 fault", 32'(rsp_fault), 32'd0);
    fetch_main(32'h4);
    chk("load5 w1 valid", 32'(rsp_valid), 32'd1);
    chk("load5 w1 data",  rsp_rdata, 32'h00000013);
    chk("load5 w1 fault", 32'(rsp_fault), 32'd0);
    fetch_main(32'h8);
    chk("load5 w2 kept",  rsp_rdata, 32'hA0000002);

    // ---- DEPTH_WORDS = 4, 17 bytes -> overflow ----
    d4_ld_start = 1'b1;
    tick();
    d4_ld_start = 1'b0;
    for (int k = 0; k < 17; k++) begin
      d4_ld_valid = 1'b1; d4_ld_byte = 8'(k + 1); d4_ld_last = (k == 16);
      tick();
      $display("[TB] d4 load byte %0d = %h ld_count=%0d ovf=%0b", k, d4_ld_byte, d4_ld_count, d4_ld_overflow);
    end
    d4_ld_valid = 1'b0; d4_ld_last = 1'b0;
    chk("d4 ld_count",    32'(d4_ld_count),    32'd4);
    chk("d4 ld_overflow", 32'(d4_ld_overflow), 32'd1);
    chk("d4 ld_ready",    32'(d4_ld_ready),    32'd0);
    fetch_d4(32'hC);
    chk("d4 w3 data",  d4_rsp_rdata, 32'h100F0E0D);
    fetch_d4(32'h10);
    chk("d4 range fault", 32'(d4_rsp_fault), 32'd1);
    chk("d4 range nop",   d4_rsp_rdata, NOP);

    // ---- reset in the middle of a load ----
    d4_ld_start = 1'b1;
    tick();
    d4_ld_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      d4_ld_valid = 1'b1; d4_ld_byte = 8'hEE; d4_ld_last = 1'b0;
      tick();
    end
    d4_ld_valid = 1'b0;
    chk("d4 midload ld_ready", 32'(d4_ld_ready), 32'd1);
    rst = 1'b1;
    #1;
    chk("d4 rst ld_ready", 32'(d4_ld_ready), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("d4 post-rst req_ready", 32'(d4_req_ready), 32'd1);
    chk("d4 post-rst ld_count",  32'(d4_ld_count),  32'd0);
    fetch_d4(32'h0);
    chk("d4 kept w0", d4_rsp_rdata, 32'h04030201);
    fetch_d4(32'h8);
    chk("d4 kept w2", d4_rsp_rdata, 32'h0C0B0A09);
`else
    // ---- loader absent: ld_* ignored, request still accepted ----
    ld_start = 1'b1; req_valid = 1'b1; req_addr = 32'h4;
    #1;
    chk("noload req_ready", 32'(req_ready), 32'd1);
    tick();
    ld_start = 1'b0; req_valid = 1'b0;
    chk("noload rsp_valid", 32'(rsp_valid), 32'd1);
    chk("noload rsp_rdata", rsp_rdata, 32'hA0000001);
    for (int k = 0; k < 5; k++) begin
      ld_valid = 1'b1; ld_byte = 8'h55; ld_last = (k == 4);
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("noload ld_count",    32'(ld_count),    32'd0);
    chk("noload ld_ready",    32'(ld_ready),    32'd0);
    chk("noload ld_overflow", 32'(ld_overflow), 32'd0);
    fetch_main(32'h0);
    chk("noload w0 intact", rsp_rdata, 32'hA0000000);
    fetch_d4(32'hC);
    chk("d4 w3 data",  d4_rsp_rdata, 32'hA0000003);
    chk("d4 w3 fault", 32'(d4_rsp_fault), 32'd0);
    fetch_d4(32'h10);
    chk("d4 range fault", 32'(d4_rsp_fault), 32'd1);
    chk("d4 range nop",   d4_rsp_rdata, NOP);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
